// File: rtl/fmul_pkg.sv
// Shared constants and FSM encoding for the FP16 multiplier datapath.
package fmul_pkg;

   localparam int FRAC_W   = 10;
   localparam int SIG_W    = FRAC_W + 1;
   localparam int PROD_W   = 2 * SIG_W;
   localparam int ITER_CNT = SIG_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      NORM = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/mant_mul_seq.sv
// Radix-2 shift-add significand multiplier with product normalization
// and guard/sticky export for the downstream rounder.
module mant_mul_seq #(
   parameter int FRAC_W = fmul_pkg::FRAC_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [FRAC_W-1:0] frac_a,
   input  logic [FRAC_W-1:0] frac_b,
   input  logic              a_zero,
   input  logic              b_zero,
   output logic              busy,
   output logic              done,
   output logic [FRAC_W-1:0] frac_out,
   output logic              norm_inc,
   output logic              guard,
   output logic              sticky
);

   import fmul_pkg::*;

   localparam int SW    = FRAC_W + 1;
   localparam int PW    = 2 * SW;
   localparam int CNT_W = $clog2(SW);

   state_t state, state_nx;

   logic [SW-1:0]    sa;
   logic [SW-1:0]    mb;
   logic [PW-1:0]    p;
   logic [CNT_W-1:0] cnt;
   logic [SW:0]      sum;
   logic             last_iter;

   assign sum       = {1'b0, p[PW-1:SW]} + {1'b0, (mb[0] ? sa : '0)};
   assign last_iter = (cnt == CNT_W'(SW - 1));
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start) state_nx = RUN;
         RUN:  if (last_iter) state_nx = NORM;
         NORM: state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // A zero operand clears its whole significand so stray fraction
   // bits can never leak into the product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa       <= '0;
         mb       <= '0;
         p        <= '0;
         cnt      <= '0;
         done     <= 1'b0;
         frac_out <= '0;
         norm_inc <= 1'b0;
         guard    <= 1'b0;
         sticky   <= 1'b0;
      end else begin
         done <= (state == NORM);
         unique case (state)
            IDLE: begin
               if (start) begin
                  sa  <= a_zero ? '0 : {1'b1, frac_a};
                  mb  <= b_zero ? '0 : {1'b1, frac_b};
                  p   <= '0;
                  cnt <= '0;
               end
            end
            RUN: begin
               p   <= {sum, p[SW-1:1]};
               mb  <= mb >> 1;
               cnt <= cnt + 1'b1;
            end
            NORM: begin
               if (p[PW-1]) begin
                  norm_inc <= 1'b1;
                  frac_out <= p[PW-2 -: FRAC_W];
                  guard    <= p[PW-2-FRAC_W];
                  sticky   <= |p[PW-3-FRAC_W:0];
               end else begin
                  norm_inc <= 1'b0;
                  frac_out <= p[PW-3 -: FRAC_W];
                  guard    <= p[PW-3-FRAC_W];
                  sticky   <= |p[PW-4-FRAC_W:0];
               end
            end
            DONE: ;
            default: ;
         endcase
      end
   end

endmodule
